// File: rtl/wl_dmem_arbiter_if.sv
// wl_dmem_arbiter_if: requester-side and SRAM-side signals of the data memory arbiter
interface wl_dmem_arbiter_if #(
  parameter int NumPorts     = 2,
  parameter int AddrWidth    = 32,
  parameter int DataWidth    = 32,
  parameter int NumWords     = 1024,
  parameter int MemAddrWidth = $clog2(NumWords)
);
  logic [NumPorts-1:0]                  req_i;
  logic [NumPorts-1:0][AddrWidth-1:0]   addr_i;
  logic [NumPorts-1:0]                  we_i;
  logic [NumPorts-1:0][DataWidth/8-1:0] be_i;
  logic [NumPorts-1:0][DataWidth-1:0]   wdata_i;
  logic [NumPorts-1:0]                  gnt_o;
  logic [NumPorts-1:0]                  rvalid_o;
  logic [NumPorts-1:0][DataWidth-1:0]   rdata_o;
  logic [NumPorts-1:0]                  err_o;
  logic                                 mem_req_o;
  logic                                 mem_we_o;
  logic [MemAddrWidth-1:0]              mem_addr_o;
  logic [DataWidth/8-1:0]               mem_be_o;
  logic [DataWidth-1:0]                 mem_wdata_o;
  logic [DataWidth-1:0]                 mem_rdata_i;
  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i, mem_rdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
  );
  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i, mem_rdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
  );
endinterface

// File: rtl/wl_dmem_arbiter.sv
// wl_dmem_arbiter: round-robin sharing of the single-port data SRAM with window decode and 1-cycle response routing
module wl_dmem_arbiter #(
  parameter int                   NumPorts     = 2,
  parameter int                   AddrWidth    = 32,
  parameter int                   DataWidth    = 32,
  parameter int                   NumWords     = 1024,
  parameter logic [AddrWidth-1:0] BaseAddr     = AddrWidth'(32'h0002_0000),
  parameter int                   MemAddrWidth = $clog2(NumWords)
) (
  input logic              clk_i,
  input logic              rst_i,
  wl_dmem_arbiter_if.slave bus
);
  localparam int                   IdxW     = $clog2(NumPorts);
  localparam logic [AddrWidth-1:0] MemBytes = AddrWidth'(NumWords * DataWidth / 8);
  localparam logic [IdxW:0]        NumP     = (IdxW + 1)'(NumPorts);
  localparam logic [IdxW-1:0]      LastP    = IdxW'(NumPorts - 1);

  logic [IdxW-1:0]      r_rr_ptr;
  logic [IdxW-1:0]      r_rsp_idx;
  logic                 r_rsp_valid;
  logic                 r_rsp_err;
  logic                 r_rsp_we;
  logic                 w_any;
  logic [IdxW-1:0]      w_win;
  logic [IdxW:0]        w_scan;
  logic [AddrWidth-1:0] w_addr;
  logic [AddrWidth-1:0] w_off;
  logic                 w_in_range;
  logic                 w_mem_req;

  // round-robin pick starting at r_rr_ptr; scanning backwards leaves the nearest requester as winner
  always_comb begin
    w_any  = 1'b0;
    w_win  = r_rr_ptr;
    w_scan = '0;
    for (int k = NumPorts - 1; k >= 0; k--) begin
      w_scan = {1'b0, r_rr_ptr} + (IdxW + 1)'(k);
      w_scan = (w_scan >= NumP) ? w_scan - NumP : w_scan;
      if (bus.req_i[w_scan[IdxW-1:0]] && !rst_i) begin
        w_any = 1'b1;
        w_win = w_scan[IdxW-1:0];
      end
    end
  end

  assign w_addr     = bus.addr_i[w_win];
  assign w_off      = w_addr - BaseAddr;
  assign w_in_range = (w_addr >= BaseAddr) && (w_off < MemBytes);
  assign w_mem_req  = w_any && w_in_range;

  assign bus.gnt_o       = w_any ? NumPorts'(1) << w_win : '0;
  assign bus.mem_req_o   = w_mem_req;
  assign bus.mem_we_o    = w_mem_req && bus.we_i[w_win];
  assign bus.mem_addr_o  = w_mem_req ? w_off[MemAddrWidth+1:2] : '0;
  assign bus.mem_be_o    = w_mem_req ? bus.be_i[w_win] : '0;
  assign bus.mem_wdata_o = w_mem_req ? bus.wdata_i[w_win] : '0;

  // move the pointer past each winner and remember who is owed a response next cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_idx   <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_we    <= 1'b0;
    end else begin
      r_rsp_valid <= w_any;
      if (w_any) begin
        r_rr_ptr  <= (w_win == LastP) ? '0 : w_win + 1'b1;
        r_rsp_idx <= w_win;
        r_rsp_err <= !w_in_range;
        r_rsp_we  <= bus.we_i[w_win];
      end
    end
  end

  // steer the single in-flight response to the port that won it; writes and errors return zero data
  always_comb begin
    bus.rvalid_o = '0;
    bus.err_o    = '0;
    bus.rdata_o  = '0;
    for (int p = 0; p < NumPorts; p++) begin
      bus.rvalid_o[p] = r_rsp_valid && (r_rsp_idx == IdxW'(p));
      bus.err_o[p]    = bus.rvalid_o[p] && r_rsp_err;
      bus.rdata_o[p]  = (bus.rvalid_o[p] && !r_rsp_err && !r_rsp_we) ? bus.mem_rdata_i : '0;
    end
  end
endmodule

// File: doc/wl_dmem_arbiter.md
Name: wl_dmem_arbiter

Overview:
- Shares the single-port core data memory between NumPorts requesters: port 0 is the Snitch core LSU, port 1 is the cluster bus AXI-Lite-to-mem bridge.
- Round-robin arbitration with one grant per cycle.
- Translates byte addresses inside the data memory window into SRAM word indices.
- Routes the 1-cycle-latency SRAM response back to the granted port; out-of-window accesses get an error response.

Parameters:
- NumPorts, 2, number of requesters (>=2).
- AddrWidth, 32, requester byte address width.
- DataWidth, 32, data width; strobe width is DataWidth/8.
- NumWords, 1024, SRAM depth in words (>=2).
- BaseAddr, 32'h0002_0000, byte base of the data memory window; NAPOT-aligned to NumWords*DataWidth/8.
- MemAddrWidth, $clog2(NumWords), SRAM word index width (derived).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req_i  in  [NumPorts]  request valid per port
- addr_i  in  [NumPorts][AddrWidth]  byte address
- we_i  in  [NumPorts]  1=write
- be_i  in  [NumPorts][DataWidth/8]  byte enables
- wdata_i  in  [NumPorts][DataWidth]  write data
- gnt_o  out  [NumPorts]  request accepted this cycle
- rvalid_o  out  [NumPorts]  response valid (reads and writes)
- rdata_o  out  [NumPorts][DataWidth]  read data
- err_o  out  [NumPorts]  response is an error; qualified by rvalid_o
- mem_req_o  out  1  SRAM access
- mem_we_o  out  1  SRAM write
- mem_addr_o  out  MemAddrWidth  SRAM word index
- mem_be_o  out  DataWidth/8  SRAM byte enables
- mem_wdata_o  out  DataWidth  SRAM write data
- mem_rdata_i  in  DataWidth  SRAM read data, valid 1 cycle after mem_req_o

Behaviour:
- One clock. Reset is asynchronous and active-high (rst_i); all state clears immediately on assertion.
- Reset values:
  - rr_ptr_q=0, rsp_valid_q=0, rsp_idx_q=0, rsp_err_q=0.
  - Hence gnt_o, rvalid_o, err_o, rdata_o and mem_* outputs all 0 while in reset.
- Arbitration is combinational in the request cycle:
  - Scan ports starting at rr_ptr_q, wrapping modulo NumPorts; the first port with req_i=1 wins.
  - gnt_o is one-hot or zero; a grant is given every cycle at least one request is present (no back-pressure from SRAM).
  - Requesters must hold req_i/addr_i/we_i/be_i/wdata_i stable until gnt_o; the arbiter does not register requests.
- Pointer update:
  - On a grant to port w: rr_ptr_q <= (w==NumPorts-1) ? 0 : w+1.
  - No grant: pointer holds.
  - Two requesters asserting continuously therefore alternate every cycle.
- Address decode for the winner:
  - offset = addr_i - BaseAddr (AddrWidth-bit, unsigned, wraps).
  - in_range = addr_i >= BaseAddr && offset < NumWords*DataWidth/8.
  - Word index = offset[MemAddrWidth+1:2]; addr_i[1:0] is ignored (no misalignment error).
- SRAM drive:
  - mem_req_o = grant && in_range.
  - mem_we_o, mem_be_o and mem_wdata_o are passed from the winner; forced to 0 when mem_req_o=0.
  - Out-of-range requests are still granted but never touch SRAM.
- Response, exactly 1 cycle after a grant:
  - rsp_valid_q=1, rsp_idx_q=w, rsp_err_q=!in_range, rsp_we_q=we.
  - rvalid_o[rsp_idx_q]=rsp_valid_q; only one rvalid_o bit is set at a time.
  - rdata_o[rsp_idx_q] = mem_rdata_i if read && !err, else 0.
  - err_o[rsp_idx_q]=rsp_err_q.
  - Non-selected ports see rvalid_o=0, rdata_o=0, err_o=0.
- Throughput and latency: one access per cycle; back-to-back grants pipeline, so the response for grant N overlaps the grant for N+1. Latency request->rvalid is 1 cycle with no contention, plus 1 cycle per losing arbitration round.
- Reset mid-operation: a response pending in the pipeline is dropped (rvalid_o never fires for it). A write already presented to SRAM in the reset-assertion cycle is not guaranteed.
- Simultaneous request from a port whose response is in flight: allowed; the new grant and the old rvalid_o occur in the same cycle.

Test Plan:
- Reset, no requests -> all outputs 0 for 10 cycles; assert rst_i mid-burst -> rvalid_o drops within the same cycle and no stale rvalid_o after release.
- Port0 writes 0xDEADBEEF to 0x0002_0010 with be=4'hF, then reads it back -> mem_addr_o=4, mem_we_o=1 on the first grant; read returns rvalid_o[0]=1, rdata_o[0]=0xDEADBEEF, err_o=0 exactly 1 cycle after gnt_o.
- Both ports request continuously for 8 cycles from reset -> grants 0,1,0,1,0,1,0,1; each port receives 4 rvalid_o; no cycle has two gnt_o bits set.
- Byte-enable write of 0x000000AA with be=4'b0001 to word 0 preset to 0x11223344 -> subsequent read returns 0x112233AA (SRAM model honors mem_be_o).
- Port1 reads 0x0003_0000 with NumWords=1024 -> gnt_o[1]=1, mem_req_o=0, next cycle rvalid_o[1]=1, err_o[1]=1, rdata_o[1]=0; rr_ptr_q advances to 0.
- Port1 only requests, at the top word 0x0002_0FFC and then 0x0001_FFFC -> top word index 1023 is accepted; 0x0001_FFFC (below base) returns an error.
